// File: rtl/requant_pipe.sv
// requant_pipe: streaming INT32 -> INTn requantizer.
// Three stages: S1 multiply by per-channel scale, S2 round and arithmetic
// shift, S3 ReLU, zero-point add and saturation. Channel parameters come from
// an internal table indexed by an auto-incrementing channel counter.
//
// Handshake: a beat moves on in_valid && in_ready and leaves on
// out_valid && out_ready. All stages advance together on
// en = !out_valid || out_ready, and in_ready is exactly en, so a stalled
// output holds every stage and keeps out_data/out_ch/out_last stable.
module requant_pipe #(
    parameter int IN_W    = 32,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 8,
    parameter int NUM_CH  = 16,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [IN_W-1:0]   in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [SCALE_W-1:0]       cfg_scale,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic signed [OUT_W-1:0]  cfg_zp,
    input  logic [1:0]               round_mode,
    input  logic                     relu_en,
    output logic                     sat_flag,
    input  logic                     sat_clr
);

    // Product width, plus one guard bit for the rounding add and zp add.
    localparam int PW = IN_W + SCALE_W + 1;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (OUT_W - 1)));

    // Channel parameter table
    logic [SCALE_W-1:0]       r_scale [NUM_CH];
    logic [SHIFT_W-1:0]       r_shift [NUM_CH];
    logic signed [OUT_W-1:0]  r_zp    [NUM_CH];

    logic [CH_W-1:0]          r_ch;

    // Stage 1 registers
    logic                     r1_valid;
    logic signed [PW-1:0]     r1_prod;
    logic [SHIFT_W-1:0]       r1_shift;
    logic signed [OUT_W-1:0]  r1_zp;
    logic [CH_W-1:0]          r1_ch;
    logic                     r1_last;
    logic [1:0]               r1_mode;
    logic                     r1_relu;

    // Stage 2 registers
    logic                     r2_valid;
    logic signed [RW-1:0]     r2_res;
    logic signed [OUT_W-1:0]  r2_zp;
    logic [CH_W-1:0]          r2_ch;
    logic                     r2_last;
    logic                     r2_relu;

    // Stage 3 (output) registers
    logic                     r3_valid;
    logic signed [OUT_W-1:0]  r3_data;
    logic [CH_W-1:0]          r3_ch;
    logic                     r3_last;
    logic                     r_sat;

    logic                     w_en;
    logic                     w_accept;
    logic signed [PW-1:0]     w_prod;
    logic signed [RW-1:0]     w_ext;
    logic signed [RW-1:0]     w_half;
    logic signed [RW-1:0]     w_disc;
    logic signed [RW-1:0]     w_trunc;
    logic signed [RW-1:0]     w_round;
    logic                     w_tie;
    logic signed [RW-1:0]     w_relu;
    logic signed [RW-1:0]     w_sum;
    logic                     w_clamp_hi;
    logic                     w_clamp_lo;
    logic signed [OUT_W-1:0]  w_out;

    assign w_en     = !r3_valid || out_ready;
    assign w_accept = in_valid && w_en;
    assign in_ready = w_en;

    // Scale is unsigned, so it is zero-extended by one bit before the signed multiply.
    assign w_prod = $signed(in_data) * $signed({1'b0, r_scale[r_ch]});

    // Table writes land on the next edge; a beat accepted on that edge still saw the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_scale[i] <= SCALE_W'(1);
                r_shift[i] <= '0;
                r_zp[i]    <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < NUM_CH)) begin
            r_scale[cfg_ch] <= cfg_scale;
            r_shift[cfg_ch] <= cfg_shift;
            r_zp[cfg_ch]    <= cfg_zp;
        end
    end

    // Channel counter: steps on each accepted beat, restarts after a row's last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch <= '0;
        end else if (w_accept) begin
            if (in_last || (r_ch == CH_W'(NUM_CH - 1))) begin
                r_ch <= '0;
            end else begin
                r_ch <= r_ch + CH_W'(1);
            end
        end
    end

    // S1: capture product and the per-beat parameters that travel with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_prod  <= '0;
            r1_shift <= '0;
            r1_zp    <= '0;
            r1_ch    <= '0;
            r1_last  <= 1'b0;
            r1_mode  <= '0;
            r1_relu  <= 1'b0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r1_prod  <= w_prod;
            r1_shift <= r_shift[r_ch];
            r1_zp    <= r_zp[r_ch];
            r1_ch    <= r_ch;
            r1_last  <= in_last;
            r1_mode  <= round_mode;
            r1_relu  <= relu_en;
        end
    end

    // S2 datapath: truncate, round-half-up, or round-half-even; huge shifts collapse to 0 or -1.
    always_comb begin
        w_ext   = RW'(r1_prod);
        w_half  = '0;
        w_disc  = '0;
        w_trunc = '0;
        w_tie   = 1'b0;
        w_round = '0;
        if (r1_shift == '0) begin
            w_round = w_ext;
        end else if (int'(r1_shift) >= PW) begin
            w_round = ((r1_mode == 2'd0) && r1_prod[PW-1]) ? {RW{1'b1}} : '0;
        end else begin
            w_half  = RW'(1) << (r1_shift - SHIFT_W'(1));
            w_disc  = w_ext & ((RW'(1) << r1_shift) - RW'(1));
            w_trunc = w_ext >>> r1_shift;
            w_tie   = (w_disc == w_half) && !w_trunc[0];
            if ((r1_mode == 2'd0) || ((r1_mode == 2'd2) && w_tie)) begin
                w_round = w_trunc;
            end else begin
                w_round = (w_ext + w_half) >>> r1_shift;
            end
        end
    end

    // S2: register the rounded, shifted result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_res   <= '0;
            r2_zp    <= '0;
            r2_ch    <= '0;
            r2_last  <= 1'b0;
            r2_relu  <= 1'b0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_res   <= w_round;
            r2_zp    <= r1_zp;
            r2_ch    <= r1_ch;
            r2_last  <= r1_last;
            r2_relu  <= r1_relu;
        end
    end

    // S3 datapath: ReLU before the zero point, then saturate to the output range.
    always_comb begin
        w_relu     = (r2_relu && (r2_res < 0)) ? '0 : r2_res;
        w_sum      = w_relu + RW'(r2_zp);
        w_clamp_hi = w_sum > SAT_MAX;
        w_clamp_lo = w_sum < SAT_MIN;
        w_out      = w_sum[OUT_W-1:0];
        if (w_clamp_hi) begin
            w_out = SAT_MAX[OUT_W-1:0];
        end else if (w_clamp_lo) begin
            w_out = SAT_MIN[OUT_W-1:0];
        end
    end

    // S3: output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_data  <= '0;
            r3_ch    <= '0;
            r3_last  <= 1'b0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            r3_data  <= w_out;
            r3_ch    <= r2_ch;
            r3_last  <= r2_last;
        end
    end

    // Sticky saturation flag; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_en && r2_valid && (w_clamp_hi || w_clamp_lo)) begin
            r_sat <= 1'b1;
        end else if (sat_clr) begin
            r_sat <= 1'b0;
        end
    end

    assign out_valid = r3_valid;
    assign out_data  = r3_data;
    assign out_ch    = r3_ch;
    assign out_last  = r3_last;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: directed and randomized stimulus against a behavioural
// requantization model with a scoreboard of expected output beats.
module tb_requant_pipe;

    localparam int IN_W    = 32;
    localparam int SCALE_W = 16;
    localparam int SHIFT_W = 6;
    localparam int OUT_W   = 8;
    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int W       = 2 + CH_W + OUT_W;
    localparam longint MAXO = (2 ** (OUT_W - 1)) - 1;
    localparam longint MINO = -(2 ** (OUT_W - 1));

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [IN_W-1:0]   in_data = '0;
    logic                     in_last = 1'b0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_last;
    logic                     cfg_we = 1'b0;
    logic [CH_W-1:0]          cfg_ch = '0;
    logic [SCALE_W-1:0]       cfg_scale = '0;
    logic [SHIFT_W-1:0]       cfg_shift = '0;
    logic signed [OUT_W-1:0]  cfg_zp = '0;
    logic [1:0]               round_mode = '0;
    logic                     relu_en = 1'b0;
    logic                     sat_flag;
    logic                     sat_clr = 1'b0;

    requant_pipe #(
        .IN_W(IN_W), .SCALE_W(SCALE_W), .SHIFT_W(SHIFT_W),
        .OUT_W(OUT_W), .NUM_CH(NUM_CH), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_scale(cfg_scale),
        .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .round_mode(round_mode), .relu_en(relu_en),
        .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // ---------------- model state ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           lat_log[$];
    int           rec_data[$];
    int           rec_ch[$];
    int           rec_last[$];
    int           sh_scale [NUM_CH];
    int           sh_shift [NUM_CH];
    int           sh_zp    [NUM_CH];
    int           m_ch = 0;
    bit           sticky_m = 1'b0;
    bit           presented = 1'b0;
    int           rdy_mode = 0;
    int           pcnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Requantization by the arithmetic definition: floor division by 2^sh,
    // then round on the remainder, ReLU, zero point and clamp.
    function automatic logic [OUT_W:0] model_q(input longint din, input longint scale,
                                               input int sh, input longint zp,
                                               input int mode, input bit relu);
        logic signed [127:0] p, d, q, r, v;
        bit sat;
        p = din;
        p = p * scale;
        d = 1;
        d = d << sh;
        q = p / d;
        r = p - q * d;
        if (r < 0) begin
            q = q - 1;
            r = r + d;
        end
        v = q;
        if (mode != 0) begin
            if (2 * r > d) v = q + 1;
            else if (2 * r == d) v = (mode == 2) ? (q[0] ? q + 1 : q) : q + 1;
        end
        if (relu && v < 0) v = 0;
        v = v + zp;
        sat = 1'b0;
        if (v > MAXO) begin
            v = MAXO;
            sat = 1'b1;
        end else if (v < MINO) begin
            v = MINO;
            sat = 1'b1;
        end
        return {sat, v[OUT_W-1:0]};
    endfunction

    function automatic int mdata(input longint din, input longint scale, input int sh,
                                 input longint zp, input int mode, input bit relu);
        logic [OUT_W:0] res;
        logic signed [OUT_W-1:0] d;
        res = model_q(din, scale, sh, zp, mode, relu);
        d = res[OUT_W-1:0];
        return int'(d);
    endfunction

    function automatic int msat(input longint din, input longint scale, input int sh,
                                input longint zp, input int mode, input bit relu);
        logic [OUT_W:0] res;
        res = model_q(din, scale, sh, zp, mode, relu);
        return int'(res[OUT_W]);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        acc_q.delete();
        presented = 1'b0;
        sticky_m = 1'b0;
        m_ch = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            sh_scale[i] = 1;
            sh_shift[i] = 0;
            sh_zp[i]    = 0;
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [OUT_W:0] m;
        logic signed [OUT_W-1:0] ed;
        if (!rst) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    if (!presented) begin
                        presented = 1'b1;
                        if (e[W-1]) sticky_m = 1'b1;
                        lat_log.push_back(cyc - acc_q[0]);
                    end
                    ed = e[OUT_W-1:0];
                    chk("out_data", out_data, ed);
                    chk("out_ch", out_ch, e[OUT_W+CH_W-1:OUT_W]);
                    chk("out_last", out_last, e[OUT_W+CH_W]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        presented = 1'b0;
                        rec_data.push_back(int'(out_data));
                        rec_ch.push_back(int'(out_ch));
                        rec_last.push_back(int'(out_last));
                    end
                end
            end
            chk("sat_flag", sat_flag, sticky_m);
            if (in_valid && in_ready) begin
                m = model_q(in_data, sh_scale[m_ch], sh_shift[m_ch], sh_zp[m_ch],
                            int'(round_mode), relu_en);
                exp_q.push_back({m[OUT_W], in_last, CH_W'(m_ch), m[OUT_W-1:0]});
                acc_q.push_back(cyc);
                m_ch = (in_last || m_ch == NUM_CH - 1) ? 0 : m_ch + 1;
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                sh_scale[cfg_ch] = int'(cfg_scale);
                sh_shift[cfg_ch] = int'(cfg_shift);
                sh_zp[cfg_ch]    = int'(cfg_zp);
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: begin
                out_ready = (pcnt == 0);
                pcnt = (pcnt == 2) ? 0 : pcnt + 1;
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int data, input bit last, input int mode, input bit relu);
        int n;
        bit acc;
        in_data = data;
        in_last = last;
        round_mode = 2'(mode);
        relu_en = relu;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int scale, input int sh, input int zp);
        cfg_we = 1'b1;
        cfg_ch = CH_W'(ch);
        cfg_scale = SCALE_W'(scale);
        cfg_shift = SHIFT_W'(sh);
        cfg_zp = OUT_W'(zp);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sat();
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        sticky_m = 1'b0;
    endtask

    task automatic clear_rec();
        rec_data.delete();
        rec_ch.delete();
        rec_last.delete();
        lat_log.delete();
    endtask

    // One beat with in_last brings the channel counter back to 0.
    task automatic sync_ch();
        send(0, 1'b1, 0, 1'b0);
        drain();
        clear_rec();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int e_id[4];
        int e_ch[4];
        int e_rnd[7];
        int e_ch6a[6];
        int e_ch6b[6];

        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Model pinned by hand-computed values.
        chk("pin_m0_15", mdata(5, 3, 2, 0, 0, 0), 3);
        chk("pin_m1_15", mdata(5, 3, 2, 0, 1, 0), 4);
        chk("pin_m2_15", mdata(5, 3, 2, 0, 2, 0), 4);
        chk("pin_m1_18", mdata(6, 3, 2, 0, 1, 0), 5);
        chk("pin_m2_18", mdata(6, 3, 2, 0, 2, 0), 4);
        chk("pin_m0_n15", mdata(-5, 3, 2, 0, 0, 0), -4);
        chk("pin_m1_n15", mdata(-5, 3, 2, 0, 1, 0), -4);
        chk("pin_zp", mdata(-20, 1, 0, 10, 0, 0), -10);
        chk("pin_relu", mdata(-20, 1, 0, 10, 0, 1), 10);
        chk("pin_sat", mdata(120, 1, 0, 10, 0, 0), 127);
        chk("pin_sat_bit", msat(120, 1, 0, 10, 0, 0), 1);
        chk("pin_bigsh_m0", mdata(-5, 3, 60, 0, 0, 0), -1);
        chk("pin_bigsh_m1", mdata(-5, 3, 60, 0, 1, 0), 0);

        // Identity after reset, with latency.
        e_id = '{5, -7, 127, -128};
        e_ch = '{0, 1, 2, 3};
        send(5, 0, 0, 0);
        send(-7, 0, 0, 0);
        send(200, 0, 0, 0);
        send(-300, 0, 0, 0);
        drain();
        chk("id_count", rec_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("id_data%0d", i), rec_data[i], e_id[i]);
            chk($sformatf("id_ch%0d", i), rec_ch[i], e_ch[i]);
        end
        chk("id_sat_flag", sat_flag, 1);
        chk("id_latency", lat_log[0], 3);
        clear_rec();
        clear_sat();
        chk("sat_cleared", sat_flag, 0);

        // Scaling and rounding on ch0.
        cfg_write(0, 3, 2, 0);
        e_rnd = '{3, 4, 4, 5, 4, -4, -4};
        send(5, 1, 0, 0);
        send(5, 1, 1, 0);
        send(5, 1, 2, 0);
        send(6, 1, 1, 0);
        send(6, 1, 2, 0);
        send(-5, 1, 0, 0);
        send(-5, 1, 1, 0);
        drain();
        chk("rnd_count", rec_data.size(), 7);
        for (int i = 0; i < 7; i++) chk($sformatf("rnd_data%0d", i), rec_data[i], e_rnd[i]);
        chk("rnd_no_sat", sat_flag, 0);
        clear_rec();

        // Zero point and ReLU on ch1.
        cfg_write(1, 1, 0, 10);
        send(0, 0, 0, 0);
        send(-20, 1, 0, 0);
        send(0, 0, 0, 0);
        send(-20, 1, 0, 1);
        send(0, 0, 0, 0);
        send(120, 1, 0, 0);
        drain();
        chk("zp_count", rec_data.size(), 6);
        chk("zp_plain", rec_data[1], -10);
        chk("zp_relu", rec_data[3], 10);
        chk("zp_sat", rec_data[5], 127);
        chk("zp_ch", rec_ch[5], 1);
        chk("zp_sat_flag", sat_flag, 1);
        clear_rec();

        // Backpressure: out_ready 1,0,0 repeating.
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 400) - 200, 0, 0, 0);
        drain();
        rdy_mode = 0;
        chk("bp_count", rec_data.size(), 8);
        clear_rec();

        // Channel wrap and in_last.
        sync_ch();
        e_ch6a = '{0, 1, 2, 0, 1, 2};
        e_ch6b = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) send(i, (i == 2), 0, 0);
        drain();
        for (int i = 0; i < 6; i++) chk($sformatf("wrap_last_ch%0d", i), rec_ch[i], e_ch6a[i]);
        chk("wrap_last_flag", rec_last[2], 1);
        clear_rec();
        sync_ch();
        for (int i = 0; i < 6; i++) send(i, 0, 0, 0);
        drain();
        for (int i = 0; i < 6; i++) chk($sformatf("wrap_ch%0d", i), rec_ch[i], e_ch6b[i]);
        clear_rec();

        // Config write racing a ch0 acceptance.
        sync_ch();
        cfg_write(0, 1, 0, 0);
        cfg_we = 1'b1;
        cfg_ch = '0;
        cfg_scale = 16'd2;
        cfg_shift = '0;
        cfg_zp = '0;
        send(10, 1, 0, 0);
        cfg_we = 1'b0;
        send(10, 1, 0, 0);
        drain();
        chk("race_old", rec_data[0], 10);
        chk("race_new", rec_data[1], 20);
        clear_rec();

        // Reset with two beats in flight.
        send(33, 0, 0, 0);
        send(44, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_no_output", rec_data.size(), 0);

        // Randomized traffic with random config, modes and backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int d;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = CH_W'($urandom_range(0, NUM_CH - 1));
                cfg_scale = ($urandom_range(0, 1) == 0) ? SCALE_W'($urandom_range(0, 8))
                                                        : SCALE_W'($urandom);
                cfg_shift = ($urandom_range(0, 1) == 0) ? SHIFT_W'($urandom_range(0, 8))
                                                        : SHIFT_W'($urandom_range(0, 63));
                cfg_zp = OUT_W'($urandom);
            end
            d = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 600)) - 300 : int'($urandom);
            send(d, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)));
            cfg_we = 1'b0;
        end
        rdy_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
